// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - NAND target model opcodes, states and status byte layout
package nand_pkg;

   localparam logic [7:0] CMD_READ    = 8'h00;
   localparam logic [7:0] CMD_READ_GO = 8'h30;
   localparam logic [7:0] CMD_PROG    = 8'h80;
   localparam logic [7:0] CMD_PROG_GO = 8'h10;
   localparam logic [7:0] CMD_STATUS  = 8'h70;
   localparam logic [7:0] CMD_ID      = 8'h90;
   localparam logic [7:0] CMD_RESET   = 8'hFF;

   localparam int ST_FAIL_BIT  = 0;
   localparam int ST_READY_BIT = 6;
   localparam int ST_NWP_BIT   = 7;

   localparam int T_RST = 4;

   typedef enum logic [3:0] {
      S_IDLE,
      S_RD_ADDR,
      S_RD_CONFIRM,
      S_BUSY_RD,
      S_RD_OUT,
      S_PG_ADDR,
      S_PG_DATA,
      S_BUSY_PG,
      S_STATUS,
      S_ID_OUT,
      S_BUSY_RST
   } state_t;

   typedef enum logic [1:0] {
      BK_NONE,
      BK_RD,
      BK_PG,
      BK_RST
   } busy_kind_t;

   // State reached by a command byte issued from a resting state.
   function automatic state_t cmd_entry(input logic [7:0] c);
      state_t r;
      case (c)
         CMD_READ:   r = S_RD_ADDR;
         CMD_PROG:   r = S_PG_ADDR;
         CMD_STATUS: r = S_STATUS;
         CMD_ID:     r = S_ID_OUT;
         CMD_RESET:  r = S_BUSY_RST;
         default:    r = S_IDLE;
      endcase
      return r;
   endfunction

   function automatic logic [7:0] status_byte(input logic ready, input logic fail);
      logic [7:0] s;
      s               = 8'h00;
      s[ST_NWP_BIT]   = 1'b1;
      s[ST_READY_BIT] = ready;
      s[ST_FAIL_BIT]  = fail;
      return s;
   endfunction

endpackage

// File: rtl/nand_target_model_if.sv
// rtl/nand_target_model_if.sv - NAND command/address/data bus between controller and target
interface nand_target_model_if;
   logic       ce_n;
   logic       cle;
   logic       ale;
   logic       we_n;
   logic       re_n;
   logic [7:0] io_in;
   logic [7:0] io_out;
   logic       io_oe;
   logic       rb_n;

   modport master (
      output ce_n, cle, ale, we_n, re_n, io_in,
      input  io_out, io_oe, rb_n
   );

   modport slave (
      input  ce_n, cle, ale, we_n, re_n, io_in,
      output io_out, io_oe, rb_n
   );
endinterface

// File: rtl/nand_edge_sync.sv
// rtl/nand_edge_sync.sv - strobe edge detection into registered write/read event pulses
module nand_edge_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ce_n,
   input  logic       cle,
   input  logic       ale,
   input  logic       we_n,
   input  logic       re_n,
   input  logic [7:0] io_in,
   output logic       w_evt,
   output logic       w_cle,
   output logic       w_ale,
   output logic [7:0] w_byte,
   output logic       r_evt,
   output logic       re_high
);

   logic we_q;
   logic re_q;
   logic we_rise;
   logic re_fall;

   assign we_rise = ~we_q & we_n;
   assign re_fall = re_q & ~re_n;
   assign re_high = re_q;

   // A write edge in the same cycle as a read edge wins; the read is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q   <= 1'b1;
         re_q   <= 1'b1;
         w_evt  <= 1'b0;
         r_evt  <= 1'b0;
         w_cle  <= 1'b0;
         w_ale  <= 1'b0;
         w_byte <= 8'h00;
      end else begin
         we_q  <= we_n;
         re_q  <= re_n;
         w_evt <= we_rise & ~ce_n;
         r_evt <= re_fall & ~we_rise & ~ce_n;
         if (we_rise) begin
            w_cle  <= cle;
            w_ale  <= ale;
            w_byte <= io_in;
         end
      end
   end

endmodule

// File: rtl/nand_target_model.sv
// rtl/nand_target_model.sv - cycle-accurate NAND target: command/address decode, page array,
// busy timing on rb_n and read data/status/ID return.
module nand_target_model
   import nand_pkg::*;
#(
   parameter int         PAGE_BYTES = 16,
   parameter int         PAGES      = 8,
   parameter int         T_READ     = 20,
   parameter int         T_PROG     = 40,
   parameter logic [7:0] ID_BYTE0   = 8'hEC,
   parameter logic [7:0] ID_BYTE1   = 8'hD3
) (
   input logic              CLK,
   input logic              reset,
   nand_target_model_if.slave bus
);

   localparam int COL_W  = $clog2(PAGE_BYTES);
   localparam int PAGE_W = $clog2(PAGES);

   state_t            state;
   state_t            state_nx;
   busy_kind_t        busy_kind;
   logic [15:0]       busy_cnt;
   logic [COL_W-1:0]  col;
   logic [PAGE_W-1:0] page;
   logic [1:0]        addr_idx;
   logic [1:0]        id_idx;
   logic              id_ok;
   logic              fail;
   logic              data_seen;
   logic              ovl;
   logic [7:0]        dout;
   logic              oe;
   logic [7:0]        buffer [PAGE_BYTES];
   logic [7:0]        mem    [PAGES][PAGE_BYTES];

   logic       w_evt, w_cle, w_ale, r_evt, re_high;
   logic [7:0] w_byte;
   logic       cmd_ev, adr_ev, dat_ev;
   logic       busy, expire;

   logic       do_addr, do_wdata, do_clr_buf, do_fail_set, do_ovl, do_id_ok;
   logic       do_busy_rd, do_busy_pg, do_busy_rst;
   logic       rd_go, rd_col_inc, rd_id_inc;
   logic [7:0] rd_byte;

   nand_edge_sync u_edge (
      .clk     (CLK),
      .rst_n   (reset),
      .ce_n    (bus.ce_n),
      .cle     (bus.cle),
      .ale     (bus.ale),
      .we_n    (bus.we_n),
      .re_n    (bus.re_n),
      .io_in   (bus.io_in),
      .w_evt   (w_evt),
      .w_cle   (w_cle),
      .w_ale   (w_ale),
      .w_byte  (w_byte),
      .r_evt   (r_evt),
      .re_high (re_high)
   );

   assign cmd_ev = w_evt & w_cle & ~w_ale;
   assign adr_ev = w_evt & w_ale & ~w_cle;
   assign dat_ev = w_evt & ~w_cle & ~w_ale;
   assign busy   = (busy_cnt != 16'd0);
   assign expire = (busy_cnt == 16'd1);

   assign bus.io_out = dout;
   assign bus.io_oe  = oe;
   assign bus.rb_n   = ~busy;

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      do_addr     = 1'b0;
      do_wdata    = 1'b0;
      do_clr_buf  = 1'b0;
      do_fail_set = 1'b0;
      do_ovl      = 1'b0;
      do_id_ok    = 1'b0;
      do_busy_rd  = 1'b0;
      do_busy_pg  = 1'b0;
      do_busy_rst = 1'b0;
      rd_go       = 1'b0;
      rd_col_inc  = 1'b0;
      rd_id_inc   = 1'b0;
      rd_byte     = 8'h00;

      if (bus.ce_n) begin
         state_nx = S_IDLE;
      end else if (cmd_ev && w_byte == CMD_RESET) begin
         state_nx    = S_BUSY_RST;
         do_busy_rst = 1'b1;
      end else if (busy) begin
         // Only status is honoured while busy; the busy state itself advances on expiry.
         if (cmd_ev && w_byte == CMD_STATUS) do_ovl = 1'b1;
         if (expire) begin
            case (state)
               S_BUSY_RD:             state_nx = S_RD_OUT;
               S_BUSY_PG, S_BUSY_RST: state_nx = S_IDLE;
               default:               state_nx = state;
            endcase
         end
      end else begin
         case (state)
            S_RD_ADDR, S_PG_ADDR: begin
               if (cmd_ev) begin
                  state_nx = S_IDLE;
               end else if (adr_ev) begin
                  do_addr = 1'b1;
                  if (addr_idx == 2'd3)
                     state_nx = (state == S_RD_ADDR) ? S_RD_CONFIRM : S_PG_DATA;
               end
            end
            S_RD_CONFIRM: begin
               if (cmd_ev) begin
                  if (w_byte == CMD_READ_GO) begin
                     state_nx   = S_BUSY_RD;
                     do_busy_rd = 1'b1;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end
            end
            S_PG_DATA: begin
               if (cmd_ev) begin
                  if (w_byte == CMD_PROG_GO) begin
                     state_nx    = S_BUSY_PG;
                     do_busy_pg  = 1'b1;
                     do_fail_set = ~data_seen;
                  end else begin
                     state_nx = cmd_entry(w_byte);
                  end
               end else if (dat_ev) begin
                  do_wdata = 1'b1;
               end
            end
            S_ID_OUT: begin
               if (!id_ok) begin
                  if (adr_ev && w_byte == 8'h00) do_id_ok = 1'b1;
                  else if (w_evt)                state_nx = S_IDLE;
               end else if (cmd_ev) begin
                  state_nx = cmd_entry(w_byte);
               end
            end
            default: begin
               if (cmd_ev) state_nx = cmd_entry(w_byte);
            end
         endcase
      end

      do_clr_buf = (state_nx == S_PG_ADDR) && (state != S_PG_ADDR);

      if (r_evt) begin
         if (ovl || state == S_STATUS) begin
            rd_go   = 1'b1;
            rd_byte = status_byte(~busy, fail);
         end else if (state == S_RD_OUT) begin
            rd_go      = 1'b1;
            rd_col_inc = 1'b1;
            rd_byte    = buffer[col];
         end else if (state == S_ID_OUT && id_ok) begin
            rd_go     = 1'b1;
            rd_id_inc = 1'b1;
            case (id_idx)
               2'd0:    rd_byte = ID_BYTE0;
               2'd1:    rd_byte = ID_BYTE1;
               default: rd_byte = 8'h00;
            endcase
         end
      end
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         col       <= '0;
         page      <= '0;
         addr_idx  <= 2'd0;
         id_idx    <= 2'd0;
         id_ok     <= 1'b0;
         fail      <= 1'b0;
         data_seen <= 1'b0;
         ovl       <= 1'b0;
         busy_cnt  <= 16'd0;
         busy_kind <= BK_NONE;
         dout      <= 8'h00;
         oe        <= 1'b0;
         for (int b = 0; b < PAGE_BYTES; b++) buffer[b] <= 8'hFF;
         for (int p = 0; p < PAGES; p++)
            for (int b = 0; b < PAGE_BYTES; b++) mem[p][b] <= 8'hFF;
      end else begin
         if (do_addr) begin
            addr_idx <= addr_idx + 2'd1;
            if (addr_idx == 2'd0) col  <= w_byte[COL_W-1:0];
            if (addr_idx == 2'd3) page <= w_byte[PAGE_W-1:0];
         end else if (state != S_RD_ADDR && state != S_PG_ADDR) begin
            addr_idx <= 2'd0;
         end

         if (do_clr_buf) begin
            for (int b = 0; b < PAGE_BYTES; b++) buffer[b] <= 8'hFF;
            fail      <= 1'b0;
            data_seen <= 1'b0;
         end
         if (do_wdata) begin
            buffer[col] <= w_byte;
            col         <= col + 1'b1;
            data_seen   <= 1'b1;
         end
         if (do_fail_set) fail <= 1'b1;
         if (do_ovl)      ovl  <= 1'b1;

         // Busy timing runs independently of state so a ce_n drop still commits.
         if (do_busy_rst) begin
            busy_cnt  <= 16'(T_RST);
            busy_kind <= BK_RST;
            fail      <= 1'b0;
            ovl       <= 1'b0;
         end else if (do_busy_rd) begin
            busy_cnt  <= 16'(T_READ);
            busy_kind <= BK_RD;
         end else if (do_busy_pg) begin
            busy_cnt  <= 16'(T_PROG);
            busy_kind <= BK_PG;
         end else if (busy) begin
            busy_cnt <= busy_cnt - 16'd1;
            if (expire) begin
               ovl       <= 1'b0;
               busy_kind <= BK_NONE;
               if (busy_kind == BK_RD) begin
                  for (int b = 0; b < PAGE_BYTES; b++) buffer[b] <= mem[page][b];
               end else if (busy_kind == BK_PG) begin
                  for (int b = 0; b < PAGE_BYTES; b++) mem[page][b] <= mem[page][b] & buffer[b];
               end
            end
         end

         if (state != S_ID_OUT) begin
            id_ok  <= 1'b0;
            id_idx <= 2'd0;
         end else if (do_id_ok) begin
            id_ok <= 1'b1;
         end

         if (bus.ce_n) begin
            oe <= 1'b0;
         end else if (rd_go) begin
            dout <= rd_byte;
            oe   <= 1'b1;
            if (rd_col_inc) col <= col + 1'b1;
            if (rd_id_inc && id_idx != 2'd2) id_idx <= id_idx + 2'd1;
         end else if (re_high) begin
            oe <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_nand_target_model.sv
// tb/tb_nand_target_model.sv - directed bench for nand_target_model with page-level model
module tb_nand_target_model;

   localparam int PB = 16;
   localparam int NP = 8;
   localparam int TR = 20;
   localparam int TP = 40;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nand_target_model_if bus_if ();

   nand_target_model #(
      .PAGE_BYTES (PB),
      .PAGES      (NP),
      .T_READ     (TR),
      .T_PROG     (TP),
      .ID_BYTE0   (8'hEC),
      .ID_BYTE1   (8'hD3)
   ) dut (
      .CLK   (clk),
      .reset (rst_n),
      .bus   (bus_if)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   logic [7:0] m_mem [NP][PB];
   logic       m_fail = 1'b0;
   bit         chk_on = 0, oe_known = 0, exp_oe = 0, rb_known = 0, exp_rb = 1;
   logic [7:0] exp_out = 8'h00;
   logic [7:0] g;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] m_status(input bit ready);
      return 8'h80 | (ready ? 8'h40 : 8'h00) | {7'b0, m_fail};
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         if (oe_known) begin
            chk("io_oe", {31'b0, bus_if.io_oe}, {31'b0, exp_oe});
            if (exp_oe) chk("io_out", {24'b0, bus_if.io_out}, {24'b0, exp_out});
         end
         if (rb_known) chk("rb_n", {31'b0, bus_if.rb_n}, {31'b0, exp_rb});
      end
   end

   task automatic bus_write(input logic c, input logic a, input logic [7:0] b);
      @(posedge clk); #1;
      bus_if.cle = c; bus_if.ale = a; bus_if.io_in = b; bus_if.we_n = 1'b0;
      @(posedge clk); #1;
      bus_if.we_n = 1'b1;
      @(posedge clk); #1;
      bus_if.cle = 1'b0; bus_if.ale = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic cmd(input logic [7:0] b); bus_write(1'b1, 1'b0, b); endtask
   task automatic adr(input logic [7:0] b); bus_write(1'b0, 1'b1, b); endtask
   task automatic dat(input logic [7:0] b); bus_write(1'b0, 1'b0, b); endtask

   task automatic addr4(input int c, input int p);
      adr(8'(c)); adr(8'h00); adr(8'h00); adr(8'(p));
   endtask

   task automatic bus_read(input logic [7:0] e, output logic [7:0] got);
      @(posedge clk); #1;
      bus_if.re_n = 1'b0; oe_known = 0;
      @(posedge clk);
      @(posedge clk); #1;
      bus_if.re_n = 1'b1; exp_out = e; exp_oe = 1; oe_known = 1;
      @(negedge clk);
      got = bus_if.io_out;
      @(posedge clk); #1;
      oe_known = 0;
      @(posedge clk); #1;
      exp_oe = 0; oe_known = 1;
   endtask

   task automatic wait_busy(input int t, input string name);
      bit fell = 0;
      int n;
      for (int i = 0; i < 20 && !fell; i++) begin
         @(negedge clk);
         fell = (bus_if.rb_n === 1'b0);
      end
      n = fell ? 1 : 0;
      while (fell && n < 2000) begin
         @(negedge clk);
         if (bus_if.rb_n !== 1'b0) break;
         n++;
      end
      chk(name, n, t);
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 200 && bus_if.rb_n !== 1'b1; i++) @(negedge clk);
      chk(name, {31'b0, bus_if.rb_n}, 32'd1);
   endtask

   task automatic do_program(input int p, input int c, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
      cmd(8'h80); addr4(c, p);
      if (n > 0) dat(d0);
      if (n > 1) dat(d1);
      rb_known = 0;
      cmd(8'h10);
      m_fail = (n == 0);
      if (n > 0) m_mem[p][c % PB]       = m_mem[p][c % PB] & d0;
      if (n > 1) m_mem[p][(c + 1) % PB] = m_mem[p][(c + 1) % PB] & d1;
      wait_busy(TP, "prog_busy_len");
      rb_known = 1;
   endtask

   task automatic do_read_setup(input int p, input int c);
      cmd(8'h00); addr4(c, p);
      rb_known = 0;
      cmd(8'h30);
      wait_busy(TR, "read_busy_len");
      rb_known = 1;
   endtask

   logic [7:0] lit_a [3];
   logic [7:0] id_exp [3];

   initial begin
      for (int p = 0; p < NP; p++)
         for (int b = 0; b < PB; b++) m_mem[p][b] = 8'hFF;
      bus_if.ce_n = 1'b0; bus_if.cle = 1'b0; bus_if.ale = 1'b0;
      bus_if.we_n = 1'b1; bus_if.re_n = 1'b1; bus_if.io_in = 8'h00;
      id_exp[0] = 8'hEC; id_exp[1] = 8'hD3; id_exp[2] = 8'h00;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_io_out", {24'b0, bus_if.io_out}, 32'h00);
      chk("reset_io_oe", {31'b0, bus_if.io_oe}, 32'd0);
      chk("reset_rb_n", {31'b0, bus_if.rb_n}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk_on = 1; oe_known = 1; exp_oe = 0; rb_known = 1; exp_rb = 1;

      cmd(8'h70); bus_read(m_status(1), g);
      chk("status_after_reset", {24'b0, g}, 32'hC0);

      do_program(2, 0, 8'hA5, 8'h5A, 2);
      do_read_setup(2, 0);
      lit_a[0] = 8'hA5; lit_a[1] = 8'h5A; lit_a[2] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
         bus_read(m_mem[2][i], g);
         chk("readback_literal", {24'b0, g}, {24'b0, lit_a[i]});
      end

      do_read_setup(2, 15);
      bus_read(m_mem[2][15], g);
      chk("wrap_byte15", {24'b0, g}, 32'hFF);
      bus_read(m_mem[2][0], g);
      chk("wrap_byte0", {24'b0, g}, 32'hA5);

      do_program(3, 4, 8'h0F, 8'h00, 1);
      do_program(3, 4, 8'hF0, 8'h00, 1);
      do_read_setup(3, 4);
      bus_read(m_mem[3][4], g);
      chk("and_program", {24'b0, g}, 32'h00);

      cmd(8'h80); addr4(0, 5);
      rb_known = 0;
      cmd(8'h10);
      m_fail = 1'b1;
      cmd(8'h70); bus_read(m_status(0), g);
      chk("status_while_busy", {24'b0, g}, 32'h81);
      wait_ready("prog_nodata_done");
      rb_known = 1;
      cmd(8'h70); bus_read(m_status(1), g);
      chk("status_fail", {24'b0, g}, 32'hC1);
      rb_known = 0;
      cmd(8'hFF);
      m_fail = 1'b0;
      wait_busy(4, "reset_busy_len");
      rb_known = 1;
      cmd(8'h70); bus_read(m_status(1), g);
      chk("status_after_ff", {24'b0, g}, 32'hC0);

      cmd(8'h90); adr(8'h00);
      for (int i = 0; i < 3; i++) begin
         bus_read(id_exp[i], g);
         chk("id_literal", {24'b0, g}, {24'b0, id_exp[i]});
      end

      cmd(8'h00); adr(8'h00); adr(8'h00);
      @(posedge clk); #1; bus_if.ce_n = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1; bus_if.ce_n = 1'b0;
      cmd(8'h70); bus_read(m_status(1), g);
      chk("status_after_ce_drop", {24'b0, g}, 32'hC0);

      cmd(8'h80); addr4(0, 6); dat(8'h3C);
      rb_known = 0;
      cmd(8'h10);
      m_fail = 1'b0;
      m_mem[6][0] = m_mem[6][0] & 8'h3C;
      @(posedge clk); #1; bus_if.ce_n = 1'b1;
      repeat (2) @(posedge clk);
      #1; bus_if.ce_n = 1'b0;
      wait_ready("ce_drop_busy_done");
      rb_known = 1;
      do_read_setup(6, 0);
      bus_read(m_mem[6][0], g);
      chk("ce_drop_commit", {24'b0, g}, 32'h3C);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

endmodule
